pi_ctl_sequencer: RTL and testbench

PI_CTL_SEQUENCER -- requirements
Module: pi_ctl_sequencer

---
 rtl/pi_ctl_sequencer_if.sv | 25 ++
 rtl/pi_ctl_sequencer.sv | 57 +++++
 tb/tb_pi_ctl_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pi_ctl_sequencer_if.sv
// pi_ctl_sequencer_if: target request and PI control bundle between a requester and the sequencer
interface pi_ctl_sequencer_if #(
  parameter int Npi = 9,
  parameter int Nout = 4,
  parameter int Nhold = 4
);
  logic [Nout-1:0][Npi-1:0] tgt_pi;
  logic [Nout-1:0][Npi-1:0] ctl_pi;
  logic tgt_valid;
  logic tgt_ready;
  logic abort;
  logic ctl_valid;
  logic busy;
  logic done;
  logic [Npi-2:0] step_max;
  logic [Nhold-1:0] hold_cycles;
  modport master(
    output tgt_pi, tgt_valid, step_max, hold_cycles, abort,
    input tgt_ready, ctl_pi, ctl_valid, busy, done
  );
  modport slave(
    input tgt_pi, tgt_valid, step_max, hold_cycles, abort,
    output tgt_ready, ctl_pi, ctl_valid, busy, done
  );
endinterface

// File: rtl/pi_ctl_sequencer.sv
// pi_ctl_sequencer: slews each PI channel toward its target along the shortest circular path in bounded steps
module pi_ctl_sequencer #(
  parameter int Npi = 9,
  parameter int Nout = 4,
  parameter int Nhold = 4
) (
  input logic clk_adc,
  input logic rstb,
  pi_ctl_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, STEP, SETTLE} state_t;
  localparam logic [Npi-1:0] HALF = Npi'(1) << (Npi - 1);
  state_t state, state_nx;
  logic [Nout-1:0][Npi-1:0] tgt_r, ctl_nx;
  logic [Nout-1:0] mv;
  logic [Npi-2:0] step_r;
  logic [Nhold-1:0] cnt;
  logic [Npi-1:0] stp;
  assign stp = step_r == '0 ? Npi'(1) : Npi'(step_r);
  for (genvar k = 0; k < Nout; k++) begin : g_ch
    logic [Npi-1:0] d, dn;
    assign d = tgt_r[k] - bus.ctl_pi[k];
    assign dn = -d;
    assign mv[k] = |d;
    // d == HALF falls on the upward side
    assign ctl_nx[k] = d <= HALF ? bus.ctl_pi[k] + (d < stp ? d : stp)
                                 : bus.ctl_pi[k] - (dn < stp ? dn : stp);
  end
  always_comb begin
    state_nx = state;
    state_nx = state != IDLE && bus.abort ? IDLE :
               state == IDLE ? (bus.tgt_valid ? STEP : IDLE) :
               state == STEP ? (|mv ? SETTLE : IDLE) :
               (cnt == '0 ? STEP : SETTLE);
  end
  assign bus.tgt_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk_adc or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      tgt_r <= '0;
      bus.ctl_pi <= '0;
      bus.ctl_valid <= 1'b0;
      bus.done <= 1'b0;
      step_r <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (bus.tgt_ready && bus.tgt_valid) tgt_r <= bus.tgt_pi;
      if (state_nx == STEP) step_r <= bus.step_max;
      if (state == STEP && state_nx == SETTLE) bus.ctl_pi <= ctl_nx;
      bus.ctl_valid <= state == STEP && state_nx == SETTLE;
      bus.done <= state == STEP && state_nx == IDLE && !bus.abort;
      cnt <= state_nx != SETTLE ? '0 : state == STEP ? bus.hold_cycles : cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_pi_ctl_sequencer.sv
// tb_pi_ctl_sequencer: directed moves with a scoreboard of expected ctl_valid/done events
module tb_pi_ctl_sequencer;
  localparam int Npi = 9;
  localparam int Nout = 4;
  localparam int Nhold = 4;
  typedef logic [Nout-1:0][Npi-1:0] vec_t;
  typedef struct {
    logic is_done;
    vec_t pi;
    int gap;
  } exp_t;
  logic clk_adc = 1'b0;
  logic rstb = 1'b0;
  pi_ctl_sequencer_if #(.Npi(Npi), .Nout(Nout), .Nhold(Nhold)) bus();
  pi_ctl_sequencer #(.Npi(Npi), .Nout(Nout), .Nhold(Nhold)) dut (
    .clk_adc(clk_adc),
    .rstb(rstb),
    .bus(bus.slave)
  );
  always #5 clk_adc = ~clk_adc;
  int cyc = 0;
  always @(posedge clk_adc) cyc <= cyc + 1;
  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;
  int last_ev = 0;
  int rst_cnt = 0;
  vec_t prev_pi;

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  function automatic vec_t mk(int a, int b, int c, int d);
    vec_t v;
    v[0] = Npi'(a);
    v[1] = Npi'(b);
    v[2] = Npi'(c);
    v[3] = Npi'(d);
    return v;
  endfunction

  function automatic void ex(bit is_d, vec_t v, int g);
    q.push_back('{is_d, v, g});
  endfunction

  // gap = clock edges since the previous event (or since the accepting edge)
  task automatic monitor();
    exp_t e;
    int seen = -1;
    forever begin
      @(negedge clk_adc);
      if (!rstb) continue;
      if (bus.ctl_valid || bus.done) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_event: ctl_valid=%0b done=%0b ctl_pi=%h, none required",
                   bus.ctl_valid, bus.done, bus.ctl_pi);
        end else begin
          e = q.pop_front();
          chk("event_kind_done", bus.done, e.is_done);
          chk("event_ctl_pi", bus.ctl_pi, e.pi);
          chk("event_gap", cyc - last_ev, e.gap);
        end
        last_ev = cyc;
      end else if (seen == rst_cnt) chk("ctl_pi_hold", bus.ctl_pi, prev_pi);
      prev_pi = bus.ctl_pi;
      seen = rst_cnt;
    end
  endtask

  task automatic issue(vec_t t, int smax, int hold, bit ab);
    chk("ready_in_idle", bus.tgt_ready, 1);
    bus.tgt_pi = t;
    bus.step_max = (Npi-1)'(smax);
    bus.hold_cycles = Nhold'(hold);
    bus.abort = ab;
    bus.tgt_valid = 1'b1;
    @(posedge clk_adc);
    #1;
    bus.tgt_valid = 1'b0;
    bus.abort = 1'b0;
    last_ev = cyc;
    chk("ready_busy_in_step", {bus.tgt_ready, bus.busy}, 2'b01);
    @(negedge clk_adc);
  endtask

  task automatic wait_idle(string name);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_adc);
      ok = q.size() == 0 && !bus.busy;
    end
    chk(name, ok, 1);
  endtask

  task automatic wait_q(string name);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_adc);
      ok = q.size() == 0;
    end
    chk(name, ok, 1);
  endtask

  initial begin
    bus.tgt_valid = 1'b0;
    bus.abort = 1'b0;
    bus.tgt_pi = '0;
    bus.step_max = '0;
    bus.hold_cycles = '0;
    fork
      monitor();
    join_none
    #3;
    chk("rst_ready_busy_valid_done", {bus.tgt_ready, bus.busy, bus.ctl_valid, bus.done}, 4'b1000);
    chk("rst_ctl_pi", bus.ctl_pi, 0);
    @(negedge clk_adc);
    rstb = 1'b1;
    // basic stepping 0 -> 10 on ch0
    ex(0, mk(4, 0, 0, 0), 1);
    ex(0, mk(8, 0, 0, 0), 4);
    ex(0, mk(10, 0, 0, 0), 4);
    ex(1, mk(10, 0, 0, 0), 4);
    issue(mk(10, 0, 0, 0), 4, 2, 0);
    wait_idle("s1_basic");
    ex(0, mk(10, 2, 0, 0), 1);
    ex(1, mk(10, 2, 0, 0), 2);
    issue(mk(10, 2, 0, 0), 4, 0, 0);
    wait_idle("s2_ch1_to_2");
    // wrap through zero
    ex(0, mk(10, 510, 0, 0), 1);
    ex(1, mk(10, 510, 0, 0), 2);
    issue(mk(10, 510, 0, 0), 4, 0, 0);
    wait_idle("s3_wrap");
    // half-circle tie goes upward
    ex(0, mk(10, 510, 255, 0), 1);
    ex(0, mk(10, 510, 256, 0), 3);
    ex(1, mk(10, 510, 256, 0), 3);
    issue(mk(10, 510, 256, 0), 255, 1, 0);
    wait_idle("s4_tie");
    ex(1, mk(10, 510, 256, 0), 1);
    issue(mk(10, 510, 256, 0), 4, 0, 0);
    wait_idle("s5_null");
    // independent channels finish on different updates
    ex(0, mk(6, 510, 256, 3), 1);
    ex(0, mk(2, 510, 256, 3), 2);
    ex(0, mk(0, 510, 256, 3), 2);
    ex(1, mk(0, 510, 256, 3), 2);
    issue(mk(0, 510, 256, 3), 4, 0, 0);
    wait_idle("s6_multi");
    ex(0, mk(0, 510, 256, 4), 1);
    ex(0, mk(0, 510, 256, 5), 2);
    ex(1, mk(0, 510, 256, 5), 2);
    issue(mk(0, 510, 256, 5), 0, 0, 0);
    wait_idle("s7_step0");
    // abort in the second settle
    ex(0, mk(4, 510, 256, 5), 1);
    ex(0, mk(8, 510, 256, 5), 4);
    issue(mk(10, 510, 256, 5), 4, 2, 0);
    wait_q("s8_pulses");
    bus.abort = 1'b1;
    @(posedge clk_adc);
    #1;
    bus.abort = 1'b0;
    chk("abort_ready_busy", {bus.tgt_ready, bus.busy}, 2'b10);
    repeat (6) @(negedge clk_adc);
    chk("abort_ctl_pi_held", bus.ctl_pi, mk(8, 510, 256, 5));
    // abort together with a request in idle still transfers
    ex(0, mk(9, 510, 256, 5), 1);
    ex(1, mk(9, 510, 256, 5), 2);
    issue(mk(9, 510, 256, 5), 4, 0, 1);
    wait_idle("s9_after_abort");
    // reset mid-settle
    ex(0, mk(13, 510, 256, 5), 1);
    issue(mk(20, 510, 256, 5), 4, 3, 0);
    wait_q("s10_pulse");
    @(negedge clk_adc);
    rstb = 1'b0;
    rst_cnt++;
    #1;
    chk("midrst_ctl_pi", bus.ctl_pi, 0);
    chk("midrst_ready_busy_valid_done", {bus.tgt_ready, bus.busy, bus.ctl_valid, bus.done}, 4'b1000);
    @(posedge clk_adc);
    #2;
    rstb = 1'b1;
    @(negedge clk_adc);
    ex(0, mk(1, 0, 0, 0), 1);
    ex(1, mk(1, 0, 0, 0), 2);
    issue(mk(1, 0, 0, 0), 4, 0, 0);
    wait_idle("s11_after_reset");
    repeat (10) @(negedge clk_adc);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
